// File: rtl/huff_pkg.sv
// rtl/huff_pkg.sv - shared constants, entry type and state encoding for huff_freq_counter
`ifndef MAX_CHAR_COUNT
`define MAX_CHAR_COUNT 5
`endif

package huff_pkg;

    // Table depth default; must equal the huff_encoder character count.
    localparam int MAX_CHAR_COUNT_DEF = `MAX_CHAR_COUNT;

    // Occurrence count width; must equal the huff_encoder freq_in element width.
    localparam int FREQ_W = 3;

    typedef struct packed {
        logic [7:0]        ch;
        logic [FREQ_W-1:0] freq;
    } huff_entry_t;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SORT    = 2'd1,
        DONE    = 2'd2
    } huff_freq_state_e;

    // Increment that sticks at the all-ones maximum instead of wrapping.
    function automatic logic [FREQ_W-1:0] freq_sat_inc(input logic [FREQ_W-1:0] f);
        return (f == {FREQ_W{1'b1}}) ? f : f + FREQ_W'(1);
    endfunction

endpackage

// File: rtl/huff_sort_layer.sv
// rtl/huff_sort_layer.sv - one odd/even compare-swap layer ordering entries by descending count
module huff_sort_layer
    import huff_pkg::*;
#(
    parameter int N = MAX_CHAR_COUNT_DEF
) (
    input  huff_entry_t [N-1:0] entries_i,
    input  logic                odd_i,
    output huff_entry_t [N-1:0] entries_o
);

    // Swap a pair only when the later entry is strictly more frequent, so ties keep first-seen order.
    always_comb begin
        entries_o = entries_i;
        for (int i = 0; i < N - 1; i++) begin
            if (((i % 2) == 1) == odd_i) begin
                if (entries_i[i].freq < entries_i[i+1].freq) begin
                    entries_o[i]   = entries_i[i+1];
                    entries_o[i+1] = entries_i[i];
                end
            end
        end
    end

endmodule

// File: rtl/huff_freq_counter.sv
// rtl/huff_freq_counter.sv - character frequency table builder feeding huff_encoder (option: HUFF_FREQ_SORT_EN)
module huff_freq_counter
    import huff_pkg::*;
#(
    parameter int MAX_CHAR_COUNT = MAX_CHAR_COUNT_DEF
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic                                  in_valid_i,
    output logic                                  in_ready_o,
    input  logic [7:0]                            in_char_i,
    input  logic                                  in_last_i,
    output logic [MAX_CHAR_COUNT-1:0][7:0]        data_out_o,
    output logic [0:MAX_CHAR_COUNT-1][FREQ_W-1:0] freq_out_o,
    output logic [$clog2(MAX_CHAR_COUNT+1)-1:0]   unique_count_o,
    output logic                                  out_valid_o,
    input  logic                                  out_ready_i,
    output logic                                  overflow_o
);

    localparam int CW = $clog2(MAX_CHAR_COUNT + 1);

    huff_freq_state_e                  state_q, state_d;
    huff_entry_t [MAX_CHAR_COUNT-1:0]  table_q, table_d;
    logic [CW-1:0]                     count_q, count_d;
    logic                              overflow_q, overflow_d;
    logic [MAX_CHAR_COUNT-1:0]         hit;

`ifdef HUFF_FREQ_SORT_EN
    localparam int LW = $clog2(MAX_CHAR_COUNT + 1);

    logic [LW-1:0]                     layer_q, layer_d;
    huff_entry_t [MAX_CHAR_COUNT-1:0]  sorted;

    // Layer parity alternates with the layer counter, starting with the even pairing.
    huff_sort_layer #(
        .N (MAX_CHAR_COUNT)
    ) u_sort_layer (
        .entries_i (table_q),
        .odd_i     (layer_q[0]),
        .entries_o (sorted)
    );
`endif

    // Parallel match of the incoming byte against occupied slots only, so empty 8'h00 slots never hit.
    always_comb begin
        hit = '0;
        for (int i = 0; i < MAX_CHAR_COUNT; i++) begin
            hit[i] = (CW'(i) < count_q) && (table_q[i].ch == in_char_i);
        end
    end

    // Next-state logic: collect counts, run the sort layers, then hold until the consumer acknowledges.
    always_comb begin
        state_d    = state_q;
        table_d    = table_q;
        count_d    = count_q;
        overflow_d = overflow_q;
`ifdef HUFF_FREQ_SORT_EN
        layer_d    = layer_q;
`endif
        case (state_q)
            COLLECT: begin
                if (in_valid_i) begin
                    if (|hit) begin
                        for (int i = 0; i < MAX_CHAR_COUNT; i++) begin
                            if (hit[i]) begin
                                table_d[i].freq = freq_sat_inc(table_q[i].freq);
                            end
                        end
                    end else if (count_q < CW'(MAX_CHAR_COUNT)) begin
                        for (int i = 0; i < MAX_CHAR_COUNT; i++) begin
                            if (CW'(i) == count_q) begin
                                table_d[i].ch   = in_char_i;
                                table_d[i].freq = FREQ_W'(1);
                            end
                        end
                        count_d = count_q + CW'(1);
                    end else begin
                        overflow_d = 1'b1;
                    end
                    if (in_last_i) begin
`ifdef HUFF_FREQ_SORT_EN
                        state_d = SORT;
                        layer_d = '0;
`else
                        state_d = DONE;
`endif
                    end
                end
            end
`ifdef HUFF_FREQ_SORT_EN
            SORT: begin
                table_d = sorted;
                layer_d = layer_q + LW'(1);
                if (layer_q == LW'(MAX_CHAR_COUNT - 1)) begin
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                if (out_ready_i) begin
                    table_d    = '0;
                    count_d    = '0;
                    overflow_d = 1'b0;
                    state_d    = COLLECT;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    // State and table registers with synchronous active-high reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= COLLECT;
            table_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
`ifdef HUFF_FREQ_SORT_EN
            layer_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            table_q    <= table_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
`ifdef HUFF_FREQ_SORT_EN
            layer_q    <= layer_d;
`endif
        end
    end

    // Entry 0 (most frequent) lands in the MSB slice of both buses, matching huff_encoder packing.
    always_comb begin
        data_out_o = '0;
        freq_out_o = '0;
        for (int k = 0; k < MAX_CHAR_COUNT; k++) begin
            data_out_o[MAX_CHAR_COUNT-1-k] = table_q[k].ch;
            freq_out_o[k]                  = table_q[k].freq;
        end
    end

    assign in_ready_o     = (state_q == COLLECT);
    assign out_valid_o    = (state_q == DONE);
    assign unique_count_o = count_q;
    assign overflow_o     = overflow_q;

endmodule
